// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with ALU control decode, operand forwarding and load-use detection.
// Define ID_EX_FORWARD_EN to enable EX/MEM and MEM/WB forwarding with stall-time operand refresh.
module id_ex_stage (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        flush,
  input  logic        id_valid,
  input  logic [31:0] id_rs_data,
  input  logic [31:0] id_rt_data,
  input  logic [31:0] id_imm,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic [4:0]  id_rd,
  input  logic [1:0]  id_aluop,
  input  logic [5:0]  id_funct,
  input  logic [5:0]  id_opcode,
  input  logic        id_alusrc,
  input  logic        id_regdst,
  input  logic        id_regwrite,
  input  logic        id_memread,
  input  logic        id_memwrite,
  input  logic        id_memtoreg,
  input  logic        exmem_regwrite,
  input  logic        memwb_regwrite,
  input  logic [4:0]  exmem_rd,
  input  logic [4:0]  memwb_rd,
  input  logic [31:0] exmem_result,
  input  logic [31:0] memwb_result,
  output logic [3:0]  alu_ctl,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [31:0] ex_store_data,
  output logic [4:0]  ex_wreg,
  output logic        ex_valid,
  output logic        ex_regwrite,
  output logic        ex_memread,
  output logic        ex_memwrite,
  output logic        ex_memtoreg,
  output logic        hazard_stall
);

  localparam logic [3:0] CTL_ADD = 4'b0010;
  localparam logic [3:0] CTL_BAD = 4'b1111;

  logic        valid_reg, regwrite_reg, memread_reg, memwrite_reg, memtoreg_reg, alusrc_reg;
  logic [4:0]  rs_reg, rt_reg, wreg_reg;
  logic [31:0] rs_data_reg, rt_data_reg, imm_reg;
  logic [3:0]  alu_ctl_reg;
  logic [3:0]  ctl_next;

  logic [4:0]  src_num [2];
  logic [31:0] src_data[2];
  logic [31:0] fwd_data[2];

  always_comb begin
    ctl_next = CTL_BAD;
    case (id_aluop)
      2'b00: ctl_next = CTL_ADD;
      2'b01: ctl_next = 4'b0110;
      2'b10: begin
        case (id_funct)
          6'b100000, 6'b100001: ctl_next = CTL_ADD;
          6'b100010, 6'b100011: ctl_next = 4'b0110;
          6'b100100:            ctl_next = 4'b0000;
          6'b100101:            ctl_next = 4'b0001;
          6'b100110:            ctl_next = 4'b1101;
          6'b100111:            ctl_next = 4'b1100;
          6'b101010:            ctl_next = 4'b0111;
          default:              ctl_next = CTL_BAD;
        endcase
      end
      default: begin
        case (id_opcode)
          6'b001000, 6'b001001: ctl_next = CTL_ADD;
          6'b001100:            ctl_next = 4'b0000;
          6'b001101:            ctl_next = 4'b0001;
          6'b001110:            ctl_next = 4'b1101;
          6'b001010:            ctl_next = 4'b0111;
          default:              ctl_next = CTL_BAD;
        endcase
      end
    endcase
  end

  assign src_num[0]  = rs_reg;
  assign src_num[1]  = rt_reg;
  assign src_data[0] = rs_data_reg;
  assign src_data[1] = rt_data_reg;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_operand
`ifdef ID_EX_FORWARD_EN
      // EX/MEM is the younger result, so it takes precedence over MEM/WB.
      always_comb begin
        fwd_data[gi] = src_data[gi];
        if (exmem_regwrite && (exmem_rd != 5'd0) && (exmem_rd == src_num[gi]))
          fwd_data[gi] = exmem_result;
        else if (memwb_regwrite && (memwb_rd != 5'd0) && (memwb_rd == src_num[gi]))
          fwd_data[gi] = memwb_result;
      end
`else
      assign fwd_data[gi] = src_data[gi];
`endif
    end
  endgenerate

`ifndef ID_EX_FORWARD_EN
  logic unused_fwd;
  assign unused_fwd = ^{exmem_regwrite, memwb_regwrite, exmem_rd, memwb_rd,
                        exmem_result, memwb_result, src_num[0]};
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n || flush) begin
      valid_reg    <= 1'b0;
      regwrite_reg <= 1'b0;
      memread_reg  <= 1'b0;
      memwrite_reg <= 1'b0;
      memtoreg_reg <= 1'b0;
      alusrc_reg   <= 1'b0;
      rs_reg       <= 5'd0;
      rt_reg       <= 5'd0;
      wreg_reg     <= 5'd0;
      rs_data_reg  <= 32'd0;
      rt_data_reg  <= 32'd0;
      imm_reg      <= 32'd0;
      alu_ctl_reg  <= CTL_ADD;
    end else if (stall) begin
`ifdef ID_EX_FORWARD_EN
      // Refresh so a writeback retiring during the stall is not lost.
      rs_data_reg <= fwd_data[0];
      rt_data_reg <= fwd_data[1];
`endif
    end else begin
      valid_reg    <= id_valid;
      regwrite_reg <= id_regwrite;
      memread_reg  <= id_memread;
      memwrite_reg <= id_memwrite;
      memtoreg_reg <= id_memtoreg;
      alusrc_reg   <= id_alusrc;
      rs_reg       <= id_rs;
      rt_reg       <= id_rt;
      wreg_reg     <= id_regdst ? id_rd : id_rt;
      rs_data_reg  <= id_rs_data;
      rt_data_reg  <= id_rt_data;
      imm_reg      <= id_imm;
      alu_ctl_reg  <= ctl_next;
    end
  end

  assign alu_ctl       = alu_ctl_reg;
  assign alu_a         = fwd_data[0];
  assign alu_b         = alusrc_reg ? imm_reg : fwd_data[1];
  assign ex_store_data = fwd_data[1];
  assign ex_wreg       = wreg_reg;
  assign ex_valid      = valid_reg;
  assign ex_regwrite   = regwrite_reg;
  assign ex_memread    = memread_reg;
  assign ex_memwrite   = memwrite_reg;
  assign ex_memtoreg   = memtoreg_reg;

  logic load_use;
  assign load_use = valid_reg & memread_reg & id_valid & (rt_reg != 5'd0) &
                    ((rt_reg == id_rs) | (rt_reg == id_rt));

`ifdef ID_EX_FORWARD_EN
  assign hazard_stall = load_use;
`else
  // Without forwarding, any pending EX write to a source of ID must be waited out.
  logic raw_dep;
  assign raw_dep = regwrite_reg & id_valid & (wreg_reg != 5'd0) &
                   ((wreg_reg == id_rs) | (wreg_reg == id_rt));
  assign hazard_stall = load_use | raw_dep;
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: expected EX state is queued at drive time and checked after the edge.
module tb_id_ex_stage;

`ifdef ID_EX_FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n, stall, flush, id_valid;
  logic [31:0] id_rs_data, id_rt_data, id_imm;
  logic [4:0]  id_rs, id_rt, id_rd;
  logic [1:0]  id_aluop;
  logic [5:0]  id_funct, id_opcode;
  logic        id_alusrc, id_regdst, id_regwrite, id_memread, id_memwrite, id_memtoreg;
  logic        exmem_regwrite, memwb_regwrite;
  logic [4:0]  exmem_rd, memwb_rd;
  logic [31:0] exmem_result, memwb_result;
  logic [3:0]  alu_ctl;
  logic [31:0] alu_a, alu_b, ex_store_data;
  logic [4:0]  ex_wreg;
  logic        ex_valid, ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg, hazard_stall;

  always #5 clk = ~clk;

  id_ex_stage dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush), .id_valid(id_valid),
    .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_aluop(id_aluop),
    .id_funct(id_funct), .id_opcode(id_opcode), .id_alusrc(id_alusrc),
    .id_regdst(id_regdst), .id_regwrite(id_regwrite), .id_memread(id_memread),
    .id_memwrite(id_memwrite), .id_memtoreg(id_memtoreg),
    .exmem_regwrite(exmem_regwrite), .memwb_regwrite(memwb_regwrite),
    .exmem_rd(exmem_rd), .memwb_rd(memwb_rd),
    .exmem_result(exmem_result), .memwb_result(memwb_result),
    .alu_ctl(alu_ctl), .alu_a(alu_a), .alu_b(alu_b), .ex_store_data(ex_store_data),
    .ex_wreg(ex_wreg), .ex_valid(ex_valid), .ex_regwrite(ex_regwrite),
    .ex_memread(ex_memread), .ex_memwrite(ex_memwrite), .ex_memtoreg(ex_memtoreg),
    .hazard_stall(hazard_stall)
  );

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    string       tag;
    logic [3:0]  ctl;
    logic [31:0] a, b, sd;
    logic [4:0]  wreg;
    logic [4:0]  flags;
  } exp_t;

  exp_t sb[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic push(input string tag, input logic [3:0] ctl, input logic [31:0] a, b, sd,
                      input logic [4:0] wreg, input logic [4:0] flags);
    exp_t e;
    e.tag = tag; e.ctl = ctl; e.a = a; e.b = b; e.sd = sd; e.wreg = wreg; e.flags = flags;
    sb.push_back(e);
  endtask

  task automatic compare_head();
    exp_t e;
    if (sb.size() == 0) begin
      check("scoreboard_empty", 32'd1, 32'd0);
      return;
    end
    e = sb.pop_front();
    check({e.tag, ".ctl"},   32'(alu_ctl), 32'(e.ctl));
    check({e.tag, ".a"},     alu_a, e.a);
    check({e.tag, ".b"},     alu_b, e.b);
    check({e.tag, ".sd"},    ex_store_data, e.sd);
    check({e.tag, ".wreg"},  32'(ex_wreg), 32'(e.wreg));
    check({e.tag, ".flags"}, 32'({ex_valid, ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg}),
          32'(e.flags));
    $display("txn %-16s ctl=%b a=%08h b=%08h sd=%08h wreg=%0d flags=%b", e.tag, alu_ctl, alu_a,
             alu_b, ex_store_data, ex_wreg,
             {ex_valid, ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg});
  endtask

  // ctrl = {alusrc, regdst, regwrite, memread, memwrite, memtoreg}
  task automatic drive(input logic [31:0] rs_d, rt_d, imm, input logic [4:0] rs, rt, rd,
                       input logic [1:0] aluop, input logic [5:0] funct, opcode, ctrl);
    id_valid = 1'b1;
    id_rs_data = rs_d; id_rt_data = rt_d; id_imm = imm;
    id_rs = rs; id_rt = rt; id_rd = rd;
    id_aluop = aluop; id_funct = funct; id_opcode = opcode;
    {id_alusrc, id_regdst, id_regwrite, id_memread, id_memwrite, id_memtoreg} = ctrl;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic fwd_idle();
    exmem_regwrite = 1'b0; memwb_regwrite = 1'b0;
    exmem_rd = 5'd0; memwb_rd = 5'd0;
    exmem_result = 32'd0; memwb_result = 32'd0;
  endtask

  // {aluop, funct, opcode, expected ctl}
  logic [17:0] dec_tab[19];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    dec_tab = '{
      {2'b00, 6'b000000, 6'b000000, 4'b0010}, {2'b01, 6'b000000, 6'b000000, 4'b0110},
      {2'b10, 6'b100000, 6'b000000, 4'b0010}, {2'b10, 6'b100001, 6'b000000, 4'b0010},
      {2'b10, 6'b100010, 6'b000000, 4'b0110}, {2'b10, 6'b100011, 6'b000000, 4'b0110},
      {2'b10, 6'b100100, 6'b000000, 4'b0000}, {2'b10, 6'b100101, 6'b000000, 4'b0001},
      {2'b10, 6'b100110, 6'b000000, 4'b1101}, {2'b10, 6'b100111, 6'b000000, 4'b1100},
      {2'b10, 6'b101010, 6'b000000, 4'b0111}, {2'b10, 6'b111111, 6'b000000, 4'b1111},
      {2'b11, 6'b000000, 6'b001000, 4'b0010}, {2'b11, 6'b000000, 6'b001001, 4'b0010},
      {2'b11, 6'b000000, 6'b001100, 4'b0000}, {2'b11, 6'b000000, 6'b001101, 4'b0001},
      {2'b11, 6'b000000, 6'b001110, 4'b1101}, {2'b11, 6'b000000, 6'b001010, 4'b0111},
      {2'b11, 6'b000000, 6'b001111, 4'b1111}
    };

    rst_n = 1'b0; stall = 1'b0; flush = 1'b0;
    drive(32'd0, 32'd0, 32'd0, 5'd0, 5'd0, 5'd0, 2'b00, 6'd0, 6'd0, 6'd0);
    id_valid = 1'b0;
    fwd_idle();
    #12;
    push("reset", 4'b0010, 32'd0, 32'd0, 32'd0, 5'd0, 5'b00000);
    compare_head();
    check("reset.hazard", 32'(hazard_stall), 32'd0);
    @(negedge clk) rst_n = 1'b1;

    // add r5 = r1 + r2
    drive(32'd5, 32'd7, 32'd0, 5'd1, 5'd2, 5'd5, 2'b10, 6'b100000, 6'd0, 6'b011000);
    push("add", 4'b0010, 32'd5, 32'd7, 32'd7, 5'd5, 5'b11000);
    step(); compare_head();
    id_rs = 5'd5; #1;
    check("raw_dep.hazard", 32'(hazard_stall), FWD ? 32'd0 : 32'd1);

    // forwarding source selection on a loaded instruction with rs=3, rt=6
    drive(32'h33, 32'h66, 32'd0, 5'd3, 5'd6, 5'd7, 2'b00, 6'd0, 6'd0, 6'b010000);
    push("fwd_base", 4'b0010, 32'h33, 32'h66, 32'h66, 5'd7, 5'b10000);
    step(); compare_head();
    exmem_regwrite = 1'b1; exmem_rd = 5'd3; exmem_result = 32'h11;
    memwb_regwrite = 1'b1; memwb_rd = 5'd3; memwb_result = 32'h22;
    #1 check("fwd_both.a", alu_a, FWD ? 32'h11 : 32'h33);
    exmem_rd = 5'd0; memwb_rd = 5'd0;
    #1 check("fwd_r0.a", alu_a, 32'h33);
    memwb_rd = 5'd3;
    #1 check("fwd_wb.a", alu_a, FWD ? 32'h22 : 32'h33);
    memwb_rd = 5'd6;
    #1 check("fwd_wb_rt.sd", ex_store_data, FWD ? 32'h22 : 32'h66);
    check("fwd_wb_rt.b", alu_b, FWD ? 32'h22 : 32'h66);
    exmem_rd = 5'd6;
    #1 check("fwd_mem_rt.sd", ex_store_data, FWD ? 32'h11 : 32'h66);
    exmem_regwrite = 1'b0;
    #1 check("fwd_mem_off.sd", ex_store_data, FWD ? 32'h22 : 32'h66);
    fwd_idle();

    // ori: immediate path and rt destination
    drive(32'h100, 32'h200, 32'hFF, 5'd7, 5'd8, 5'd9, 2'b11, 6'd0, 6'b001101, 6'b101000);
    push("ori", 4'b0001, 32'h100, 32'hFF, 32'h200, 5'd8, 5'b11000);
    step(); compare_head();

    for (int i = 0; i < 19; i++) begin
      logic [17:0] ent;
      logic [31:0] rsd, rtd, imd;
      ent = dec_tab[i];
      rsd = 32'h1000 + 32'(i); rtd = 32'h2000 + 32'(i); imd = 32'h3000 + 32'(i);
      drive(rsd, rtd, imd, 5'd1, 5'd2, 5'd3, ent[17:16], ent[15:10], ent[9:4],
            {i[0], 5'b11000});
      push($sformatf("decode%0d", i), ent[3:0], rsd, i[0] ? imd : rtd, rtd, 5'd3, 5'b11000);
      step(); compare_head();
    end

    // lw in EX, then load-use detection and flush
    drive(32'h40, 32'h50, 32'h8, 5'd2, 5'd4, 5'd0, 2'b00, 6'd0, 6'b100011, 6'b101101);
    push("lw", 4'b0010, 32'h40, 32'h8, 32'h50, 5'd4, 5'b11101);
    step(); compare_head();
    id_rs = 5'd4; id_rt = 5'd10;
    #1 check("load_use_rs.hazard", 32'(hazard_stall), 32'd1);
    id_rs = 5'd10; id_rt = 5'd4;
    #1 check("load_use_rt.hazard", 32'(hazard_stall), 32'd1);
    id_rt = 5'd12;
    #1 check("no_dep.hazard", 32'(hazard_stall), 32'd0);
    id_rs = 5'd4; id_valid = 1'b0;
    #1 check("id_invalid.hazard", 32'(hazard_stall), 32'd0);
    id_valid = 1'b1; flush = 1'b1;
    push("flush", 4'b0010, 32'd0, 32'd0, 32'd0, 5'd0, 5'b00000);
    step(); compare_head();
    flush = 1'b0;
    check("after_flush.hazard", 32'(hazard_stall), 32'd0);

    // two-cycle stall with a MEM/WB write to rs during the first stall cycle
    drive(32'h13, 32'h14, 32'd0, 5'd13, 5'd14, 5'd15, 2'b00, 6'd0, 6'd0, 6'b011000);
    push("pre_stall", 4'b0010, 32'h13, 32'h14, 32'h14, 5'd15, 5'b11000);
    step(); compare_head();
    drive(32'hDEAD, 32'hBEEF, 32'h1, 5'd1, 5'd1, 5'd1, 2'b01, 6'd0, 6'd0, 6'b000111);
    stall = 1'b1;
    memwb_regwrite = 1'b1; memwb_rd = 5'd13; memwb_result = 32'h99;
    step();
    fwd_idle();
    #1 check("stall1.a", alu_a, FWD ? 32'h99 : 32'h13);
    step();
    stall = 1'b0;
    #1;
    push("stall_release", 4'b0010, FWD ? 32'h99 : 32'h13, 32'h14, 32'h14, 5'd15, 5'b11000);
    compare_head();
    push("sub_load", 4'b0110, 32'hDEAD, 32'hBEEF, 32'hBEEF, 5'd1, 5'b10111);
    step(); compare_head();

    // stall and flush together: flush wins
    stall = 1'b1; flush = 1'b1;
    push("stall_flush", 4'b0010, 32'd0, 32'd0, 32'd0, 5'd0, 5'b00000);
    step(); compare_head();
    stall = 1'b0; flush = 1'b0;

    // reset asserted mid-stall, then a normal load after release
    drive(32'd5, 32'd7, 32'd0, 5'd1, 5'd2, 5'd5, 2'b10, 6'b100000, 6'd0, 6'b011000);
    push("add2", 4'b0010, 32'd5, 32'd7, 32'd7, 5'd5, 5'b11000);
    step(); compare_head();
    stall = 1'b1;
    step();
    rst_n = 1'b0;
    #1;
    push("reset_mid_stall", 4'b0010, 32'd0, 32'd0, 32'd0, 5'd0, 5'b00000);
    compare_head();
    check("reset_mid_stall.hazard", 32'(hazard_stall), 32'd0);
    @(negedge clk);
    rst_n = 1'b1; stall = 1'b0;
    drive(32'h21, 32'h22, 32'd0, 5'd1, 5'd2, 5'd3, 2'b10, 6'b100010, 6'd0, 6'b011000);
    push("post_reset", 4'b0110, 32'h21, 32'h22, 32'h22, 5'd3, 5'b11000);
    step(); compare_head();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
